// File: rtl/command_deframer.sv
// command_deframer: byte-serial front end for command_controller.
// Collects PACKET_WORDS words of WORD_WIDTH bits ({cmd, addr, value MSB..LSB})
// into one packet and presents it as a single-cycle o_data/o_dv strobe.
// Unknown command words and stalled partial packets are reported with
// one-cycle error pulses; o_data only ever changes on a good packet.
//
// Optional feature macro: CMD_DEFRAMER_CHECKSUM_EN
//   When defined, each packet carries a trailing XOR checksum word that is
//   verified before emission (mismatch pulses o_err_chk instead of o_dv).
//   When undefined, o_err_chk is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a valid command word
// COLLECT | packet partially collected, inter-word timer running
// EMIT    | packet strobe cycle; incoming words treated as in IDLE
module command_deframer #(
    parameter int WORD_WIDTH     = 8,
    parameter int PACKET_WORDS   = 6,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter logic [WORD_WIDTH-1:0] READ_CMD  = 8'h00,
    parameter logic [WORD_WIDTH-1:0] WRITE_CMD = 8'hAA
) (
    input  logic                               clk,
    input  logic                               i_reset_n,
    input  logic [WORD_WIDTH-1:0]              i_data,
    input  logic                               i_dv,
    output logic [WORD_WIDTH*PACKET_WORDS-1:0] o_data,
    output logic                               o_dv,
    output logic                               o_busy,
    output logic                               o_err_cmd,
    output logic                               o_err_timeout,
    output logic                               o_err_chk
);

    localparam int PKT_W = WORD_WIDTH * PACKET_WORDS;
`ifdef CMD_DEFRAMER_CHECKSUM_EN
    localparam int TOTAL_WORDS = PACKET_WORDS + 1;
`else
    localparam int TOTAL_WORDS = PACKET_WORDS;
`endif
    localparam int CNT_W = $clog2(TOTAL_WORDS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PKT_W-1:0]   shift_q;
    logic [PKT_W-1:0]   shifted;
    logic [CNT_W-1:0]   count_q;
    logic [TMR_W-1:0]   timer_q;
    logic               err_cmd_q;
    logic               err_timeout_q;
    logic               is_cmd;
    logic               last_word;
    logic               timer_expire;

    assign is_cmd       = (i_data == READ_CMD) || (i_data == WRITE_CMD);
    assign last_word    = i_dv && (count_q == CNT_W'(TOTAL_WORDS - 1));
    // The word wins over an expiring timer: expiry only counts on an idle clock.
    assign timer_expire = !i_dv && (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1));
    assign shifted      = {shift_q[PKT_W-WORD_WIDTH-1:0], i_data};

`ifdef CMD_DEFRAMER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] chk_q;
    logic                  chk_ok;
    logic                  err_chk_q;

    // chk_q already holds the XOR of every payload word when the checksum arrives.
    assign chk_ok    = (chk_q == i_data);
    assign o_err_chk = err_chk_q;
`else
    assign o_err_chk = 1'b0;
`endif

    assign o_err_cmd     = err_cmd_q;
    assign o_err_timeout = err_timeout_q;

    // State register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; EMIT behaves like IDLE so back-to-back packets lose nothing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, EMIT: begin
                state_d = (i_dv && is_cmd) ? COLLECT : IDLE;
            end
            COLLECT: begin
                if (last_word) begin
`ifdef CMD_DEFRAMER_CHECKSUM_EN
                    state_d = chk_ok ? EMIT : IDLE;
`else
                    state_d = EMIT;
`endif
                end else if (timer_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs derived from the current state.
    always_comb begin
        o_dv   = (state_q == EMIT);
        o_busy = (state_q == COLLECT);
    end

    // Datapath: shift register, word counter, inter-word timer, packet and error registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_q       <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            o_data        <= '0;
            err_cmd_q     <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef CMD_DEFRAMER_CHECKSUM_EN
            chk_q         <= '0;
            err_chk_q     <= 1'b0;
`endif
        end else begin
            err_cmd_q     <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef CMD_DEFRAMER_CHECKSUM_EN
            err_chk_q     <= 1'b0;
`endif
            case (state_q)
                COLLECT: begin
                    if (i_dv) begin
                        timer_q <= '0;
                        count_q <= count_q + 1'b1;
                        // The checksum word is never shifted into the packet.
                        if (count_q < CNT_W'(PACKET_WORDS)) begin
                            shift_q <= shifted;
                        end
`ifdef CMD_DEFRAMER_CHECKSUM_EN
                        chk_q <= chk_q ^ i_data;
`endif
                        if (last_word) begin
                            count_q <= '0;
`ifdef CMD_DEFRAMER_CHECKSUM_EN
                            if (chk_ok) begin
                                o_data <= shift_q;
                            end else begin
                                err_chk_q <= 1'b1;
                            end
`else
                            o_data <= shifted;
`endif
                        end
                    end else if (timer_expire) begin
                        err_timeout_q <= 1'b1;
                        count_q       <= '0;
                        timer_q       <= '0;
                    end else if (timer_q != TMR_W'(TIMEOUT_CYCLES)) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    if (i_dv) begin
                        if (is_cmd) begin
                            shift_q <= PKT_W'(i_data);
                            count_q <= CNT_W'(1);
                            timer_q <= '0;
`ifdef CMD_DEFRAMER_CHECKSUM_EN
                            chk_q   <= i_data;
`endif
                        end else begin
                            err_cmd_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_command_deframer.sv
// Testbench for command_deframer: directed scenarios plus random word
// streams, checked by a scoreboard fed from a word-stream reference model.
module tb_command_deframer;

    localparam int WW  = 8;
    localparam int PW  = 6;
    localparam int TMO = 16;
    localparam logic [7:0] RD = 8'h00;
    localparam logic [7:0] WR = 8'hAA;
`ifdef CMD_DEFRAMER_CHECKSUM_EN
    localparam int TOT = PW + 1;
`else
    localparam int TOT = PW;
`endif
    localparam int K_DV  = 0;
    localparam int K_CMD = 1;
    localparam int K_TMO = 2;
    localparam int K_CHK = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [47:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [7:0]  i_data;
    logic        i_dv;
    logic [47:0] o_data;
    logic        o_dv;
    logic        o_busy;
    logic        o_err_cmd;
    logic        o_err_timeout;
    logic        o_err_chk;

    always #5 clk = ~clk;

    command_deframer #(
        .WORD_WIDTH    (WW),
        .PACKET_WORDS  (PW),
        .TIMEOUT_CYCLES(TMO),
        .READ_CMD      (RD),
        .WRITE_CMD     (WR)
    ) dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_data       (i_data),
        .i_dv         (i_dv),
        .o_data       (o_data),
        .o_dv         (o_dv),
        .o_busy       (o_busy),
        .o_err_cmd    (o_err_cmd),
        .o_err_timeout(o_err_timeout),
        .o_err_chk    (o_err_chk)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ev_t         exp_q[$];
    bit          busy_exp[int];
    logic [7:0]  coll[$];
    int          gap_cnt   = 0;
    logic [47:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model at word-stream level: what the receiver should report
    // after the clock edge at cycle c that samples (dv, d).
    task automatic model_step(input bit dv, input logic [7:0] d, input int c);
        ev_t         e;
        logic [47:0] pkt;
        logic [7:0]  x;
        if (coll.size() == 0) begin
            if (dv) begin
                if (d == RD || d == WR) begin
                    coll.push_back(d);
                    gap_cnt = 0;
                end else begin
                    e = '{kind: K_CMD, cyc: c, data: last_data};
                    exp_q.push_back(e);
                end
            end
        end else if (dv) begin
            coll.push_back(d);
            gap_cnt = 0;
            if (coll.size() == TOT) begin
                pkt = '0;
                x   = '0;
                for (int i = 0; i < PW; i++) begin
                    pkt = {pkt[39:0], coll[i]};
                    x   = x ^ coll[i];
                end
                if (TOT > PW && x != coll[TOT-1]) begin
                    e = '{kind: K_CHK, cyc: c, data: last_data};
                end else begin
                    last_data = pkt;
                    e = '{kind: K_DV, cyc: c, data: pkt};
                end
                exp_q.push_back(e);
                coll.delete();
            end
        end else begin
            gap_cnt++;
            if (gap_cnt == TMO) begin
                e = '{kind: K_TMO, cyc: c, data: last_data};
                exp_q.push_back(e);
                coll.delete();
            end
        end
        busy_exp[c] = (coll.size() != 0);
    endtask

    task automatic step(input bit dv, input logic [7:0] d);
        @(negedge clk);
        i_dv   = dv;
        i_data = dv ? d : 8'h00;
        model_step(dv, d, cyc + 1);
    endtask

    task automatic send_pkt(input logic [47:0] p, input int gap, input bit bad_chk);
        logic [7:0] w;
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < PW; i++) begin
            if (i > 0) repeat (gap) step(1'b0, 8'h00);
            w = p[47-8*i -: 8];
            x = x ^ w;
            step(1'b1, w);
        end
        if (TOT > PW) begin
            repeat (gap) step(1'b0, 8'h00);
            step(1'b1, bad_chk ? (x ^ 8'h01) : x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        i_reset_n = 1'b0;
        i_dv      = 1'b0;
        coll.delete();
        gap_cnt   = 0;
        last_data = '0;
        #1;
        check("rst_o_data", {16'h0, o_data}, 64'h0);
        check("rst_o_dv", {63'h0, o_dv}, 64'h0);
        check("rst_o_busy", {63'h0, o_busy}, 64'h0);
        check("rst_errs", {61'h0, o_err_cmd, o_err_timeout, o_err_chk}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    // Monitor: compares o_busy each cycle and pops the scoreboard on every event.
    always @(negedge clk) begin
        int  nev;
        int  kind;
        ev_t e;
        if (i_reset_n === 1'b1) begin
            if (busy_exp.exists(cyc)) begin
                check("o_busy", {63'h0, o_busy}, {63'h0, busy_exp[cyc]});
                busy_exp.delete(cyc);
            end
            nev = int'(o_dv) + int'(o_err_cmd) + int'(o_err_timeout) + int'(o_err_chk);
            if (nev != 0) begin
                kind = o_dv ? K_DV : o_err_cmd ? K_CMD : o_err_timeout ? K_TMO : K_CHK;
                check("single_event", 64'(nev), 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(kind), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 64'(kind), 64'(e.kind));
                    check("event_cycle", 64'(cyc), 64'(e.cyc));
                    check("o_data", {16'h0, o_data}, {16'h0, e.data});
                end
            end
        end
    end

    initial begin
        logic [7:0] w;
        int         r;
        int         k;
        i_reset_n = 1'b0;
        i_dv      = 1'b0;
        i_data    = 8'h00;
        #3;
        check("init_o_data", {16'h0, o_data}, 64'h0);
        check("init_outs", {59'h0, o_dv, o_busy, o_err_cmd, o_err_timeout, o_err_chk}, 64'h0);
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;

        // Read packet, one word every 10 clocks.
        send_pkt(48'h001212345678, 9, 1'b0);
        repeat (3) step(1'b0, 8'h00);

        // Invalid start word then a write packet.
        step(1'b1, 8'h55);
        send_pkt(48'hAA2187654321, 0, 1'b0);
        repeat (3) step(1'b0, 8'h00);

        // Timeout after 16 idle clocks, then 15-clock gaps survive.
        step(1'b1, 8'h00);
        step(1'b1, 8'h12);
        repeat (TMO + 2) step(1'b0, 8'h00);
        send_pkt(48'h001212345678, TMO - 1, 1'b0);
        repeat (3) step(1'b0, 8'h00);

        // Two packets on consecutive clocks.
        send_pkt(48'h001212345678, 0, 1'b0);
        send_pkt(48'hAA2187654321, 0, 1'b0);
        repeat (3) step(1'b0, 8'h00);

        // Reset mid-packet, then a clean packet.
        step(1'b1, 8'hAA);
        step(1'b1, 8'h21);
        step(1'b1, 8'h87);
        do_reset();
        send_pkt(48'h00C0FFEE0001, 0, 1'b0);
        repeat (3) step(1'b0, 8'h00);

`ifdef CMD_DEFRAMER_CHECKSUM_EN
        send_pkt(48'h001212345678, 0, 1'b0);
        send_pkt(48'h001212345678, 0, 1'b1);
        repeat (3) step(1'b0, 8'h00);
`endif

        // Random stream.
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do w = 8'($urandom); while (w == RD || w == WR);
                step(1'b1, w);
            end else if (r == 1) begin
                k = $urandom_range(1, TOT - 1);
                step(1'b1, ($urandom_range(0, 1) != 0) ? WR : RD);
                for (int j = 1; j < k; j++) step(1'b1, 8'($urandom));
                repeat ($urandom_range(TMO - 2, TMO + 3)) step(1'b0, 8'h00);
            end else begin
                send_pkt({(($urandom_range(0, 1) != 0) ? WR : RD), 40'($urandom), 8'($urandom)},
                         $urandom_range(0, 3) == 0 ? $urandom_range(0, TMO - 1) : 0,
                         $urandom_range(0, 3) == 0);
            end
            repeat ($urandom_range(0, 3)) step(1'b0, 8'h00);
        end
        repeat (TMO + 4) step(1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/command_deframer.md
Name: command_deframer

Overview:
- Byte-serial front end for command_controller. Collects WORD_WIDTH-bit words from the UART receiver into one command packet of PACKET_WORDS words: {cmd, addr, value[31:24] .. value[7:0]}.
- Presents the packet as a single-cycle i_data/i_dv strobe to command_controller.
- Rejects unknown command bytes and aborts partial packets on an inter-word timeout.

Parameters:
- WORD_WIDTH, 8, bits per received word.
- PACKET_WORDS, 6, words per packet (1 cmd + 1 addr + 4 value).
- TIMEOUT_CYCLES, 1000, idle clocks allowed between words inside a packet; must be ≥ 2.
- READ_CMD, 8'h00, valid read command word.
- WRITE_CMD, 8'hAA, valid write command word.

Ports:
- clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_data  input  WORD_WIDTH  received word; valid when i_dv=1.
- i_dv  input  1  one-cycle word strobe.
- o_data  output  WORD_WIDTH*PACKET_WORDS  assembled packet; cmd word in the MSBs.
- o_dv  output  1  one-cycle packet strobe.
- o_busy  output  1  high while a packet is partially collected.
- o_err_cmd  output  1  one-cycle pulse: first word not READ_CMD/WRITE_CMD.
- o_err_timeout  output  1  one-cycle pulse: partial packet aborted.
- o_err_chk  output  1  one-cycle pulse: checksum mismatch (see Optional Feature).

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - All outputs go to 0; o_data is 0.
  - Shift register, word counter and timer clear; state goes to IDLE.
  - Reset mid-packet discards the partial packet; no error pulse is generated.
- States: IDLE, COLLECT, EMIT.
- IDLE:
  - i_dv with i_data == READ_CMD or WRITE_CMD: load the word into the shift register, set count=1, clear timer, go to COLLECT.
  - i_dv with any other value: pulse o_err_cmd the next cycle, discard the word, stay in IDLE.
- COLLECT:
  - o_busy=1.
  - Each i_dv shifts the register left by WORD_WIDTH, inserts i_data in the LSBs, increments count and clears the timer.
  - When the accepted word makes count == PACKET_WORDS, go to EMIT.
  - With no i_dv, the timer increments.
  - If the timer reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES consecutive clocks without i_dv), pulse o_err_timeout, clear the counter and go to IDLE.
  - If i_dv arrives in the same cycle the timer would expire, the word wins: it is accepted and the timer clears.
- EMIT (exactly one cycle):
  - o_dv=1 and o_data is updated to the packet; o_dv rises on the clock edge that captures the final word.
  - o_data holds its value until the next EMIT; it never changes on error or abort.
  - i_dv during EMIT is evaluated exactly as in IDLE, so back-to-back packets lose no words.
- Widths:
  - Word counter is $clog2(PACKET_WORDS+1) bits.
  - Timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
- No backpressure: command_controller accepts every o_dv.

Optional Feature:
- Macro: CMD_DEFRAMER_CHECKSUM_EN.
- Defined:
  - The packet carries one extra trailing word: the XOR of all PACKET_WORDS words.
  - COLLECT ends after PACKET_WORDS+1 words; the timeout applies to the checksum word too.
  - Checksum match: EMIT as normal; the checksum is not part of o_data.
  - Mismatch: pulse o_err_chk, no o_dv, o_data unchanged, return to IDLE.
- Undefined: packets are PACKET_WORDS words and o_err_chk is tied to 0.

Test Plan:
- Read packet 00 12 12 34 56 78, one word every 10 clocks → one-cycle o_dv with o_data=48'h001212345678; o_busy high from word 1 to word 6.
- Invalid start word 0x55, then AA 21 87 65 43 21 → o_err_cmd pulse only for 0x55, then o_dv with o_data=48'hAA2187654321.
- TIMEOUT_CYCLES=16:
  - Send 00 12, then 16 idle clocks → o_err_timeout pulse, o_busy falls, no o_dv.
  - Repeat with a 15-clock gap before the next word → no timeout.
- 12 words on consecutive clocks (00 12 12 34 56 78 AA 21 87 65 43 21) → two o_dv pulses exactly 6 clocks apart with the correct values.
- Assert i_reset_n=0 after AA 21 87 → all outputs 0; after release, a full packet decodes correctly and no stale words appear in o_data.
- With CMD_DEFRAMER_CHECKSUM_EN:
  - 00 12 12 34 56 78 1A → o_dv, o_data=48'h001212345678.
  - Same packet with checksum 1B → o_err_chk pulse, no o_dv.
